alu_share_arbiter: RTL and testbench

//  Shares one combinational alu instance between two requesters (0: CPU datapath, 1: debug/coprocessor port).

---
 rtl/alu_ctl_pkg.sv | 37 +++
 rtl/alu.sv | 48 ++++
 rtl/alu_share_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_share_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_ctl_pkg.sv
// -----------------------------------------------------------------------------
// alu_ctl_pkg
// Shared definitions for the ALU-sharing arbiter:
//   - ALU opcode constants (ALU_ADD .. ALU_SRA)
//   - aluc_is_legal(): 1 when an opcode is one the ALU implements
//   - state_t: arbiter FSM encoding (ST_IDLE=0, ST_EXEC=1, ST_RESP=2)
// -----------------------------------------------------------------------------
package alu_ctl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_PASB = 4'b0010;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_POPC = 4'b1111;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic aluc_is_legal(input logic [3:0] aluc);
    logic ok;
    case (aluc)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_PASB, ALU_SLL, ALU_SRL, ALU_POPC, ALU_SRA: ok = 1'b1;
      default:                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/alu.sv
// -----------------------------------------------------------------------------
// alu
// Purely combinational 32-bit ALU. Results wrap at 32 bits; shifts use the
// whole of i_b as the shift amount, so amounts >= 32 give 0 (sll/srl) or a
// full sign fill (sra). Unknown opcodes produce 0.
// Ports:
//   i_a, i_b  in  32  operands
//   i_aluc    in  4   opcode (see alu_ctl_pkg)
//   o_s       out 32  result
//   o_z       out 1   1 when o_s == 0
// -----------------------------------------------------------------------------
module alu
  import alu_ctl_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_aluc,
  output logic [31:0] o_s,
  output logic        o_z
);

  function automatic logic [31:0] popcount32(input logic [31:0] v);
    logic [31:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) cnt = cnt + {31'd0, v[i]};
    return cnt;
  endfunction

  always_comb begin
    o_s = '0;
    case (i_aluc)
      ALU_ADD:  o_s = i_a + i_b;
      ALU_SUB:  o_s = i_a - i_b;
      ALU_AND:  o_s = i_a & i_b;
      ALU_OR:   o_s = i_a | i_b;
      ALU_XOR:  o_s = i_a ^ i_b;
      ALU_PASB: o_s = i_b;
      ALU_SLL:  o_s = i_a << i_b;
      ALU_SRL:  o_s = i_a >> i_b;
      ALU_POPC: o_s = popcount32(i_a ^ i_b);
      ALU_SRA:  o_s = 32'($signed(i_a) >>> i_b);
      default:  o_s = '0;
    endcase
  end

  assign o_z = (o_s == 32'd0);

endmodule

// File: rtl/alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one ALU between two requesters (0: CPU datapath, 1: debug/coproc).
// A request is arbitrated and latched in IDLE, executed in EXEC, and the
// registered result is offered to the owning requester in RESP.
//
// Handshake rule for every channel: a transfer happens on a rising clock edge
// where valid and ready are both 1. A producer keeps valid (and its payload)
// asserted until that edge; rsp_valid is never withdrawn before its transfer.
//
// Ports:
//   clock, reset      in       rising-edge clock, async active-high reset
//   req_valid[1:0]    in       request valid per requester
//   req_ready[1:0]    out      accept, only granted requester, only in IDLE
//   req_a/req_b       in  2x32 operands {req1, req0}
//   req_aluc          in  2x4  opcodes
//   req_tag           in  2xTAG_W tags
//   rsp_valid[1:0]    out      response valid, owner's bit only
//   rsp_ready[1:0]    in       response accept; non-owner bit ignored
//   rsp_s/z/err/tag   out      result, zero flag, illegal-opcode flag, tag
//   busy              out      high in EXEC and RESP
//   dbg_state         out 2    current FSM state (state_t encoding)
// -----------------------------------------------------------------------------
module alu_share_arbiter
  import alu_ctl_pkg::*;
#(
  parameter int TAG_W     = 4,
  parameter int PRIO_MODE = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [1:0]           req_valid,
  output logic [1:0]           req_ready,
  input  logic [63:0]          req_a,
  input  logic [63:0]          req_b,
  input  logic [7:0]           req_aluc,
  input  logic [2*TAG_W-1:0]   req_tag,
  output logic [1:0]           rsp_valid,
  input  logic [1:0]           rsp_ready,
  output logic [31:0]          rsp_s,
  output logic                 rsp_z,
  output logic                 rsp_err,
  output logic [TAG_W-1:0]     rsp_tag,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  state_t             r_state;
  logic               r_rr_ptr;
  logic               r_owner;
  logic [31:0]        r_a;
  logic [31:0]        r_b;
  logic [3:0]         r_aluc;
  logic [TAG_W-1:0]   r_tag;
  logic [1:0]         r_rsp_valid;
  logic [31:0]        r_rsp_s;
  logic               r_rsp_z;
  logic               r_rsp_err;
  logic [TAG_W-1:0]   r_rsp_tag;
  logic               r_busy;

  logic               w_gnt_any;
  logic               w_gnt_idx;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;
  logic [3:0]         w_sel_aluc;
  logic [TAG_W-1:0]   w_sel_tag;
  logic [31:0]        w_alu_s;
  logic               w_alu_z;
  logic               w_err;
  logic               w_rsp_hs;

  // Tie: round-robin pointer or fixed priority to 0. A lone requester always
  // wins, whatever the pointer says.
  always_comb begin
    w_gnt_any = |req_valid;
    w_gnt_idx = 1'b0;
    if (req_valid == 2'b11) w_gnt_idx = (PRIO_MODE != 0) ? 1'b0 : r_rr_ptr;
    else                    w_gnt_idx = req_valid[1];
  end

  assign req_ready  = (r_state == ST_IDLE && w_gnt_any) ? (2'b01 << w_gnt_idx) : 2'b00;

  assign w_sel_a    = w_gnt_idx ? req_a[63:32]   : req_a[31:0];
  assign w_sel_b    = w_gnt_idx ? req_b[63:32]   : req_b[31:0];
  assign w_sel_aluc = w_gnt_idx ? req_aluc[7:4]  : req_aluc[3:0];
  assign w_sel_tag  = w_gnt_idx ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];

  alu u_alu (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_aluc (r_aluc),
    .o_s    (w_alu_s),
    .o_z    (w_alu_z)
  );

  assign w_err    = !aluc_is_legal(r_aluc);
  // r_rsp_valid only ever has the owner's bit set, so the non-owner's
  // rsp_ready cannot complete the transfer.
  assign w_rsp_hs = |(r_rsp_valid & rsp_ready);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= 1'b0;
      r_owner     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_aluc      <= '0;
      r_tag       <= '0;
      r_rsp_valid <= 2'b00;
      r_rsp_s     <= '0;
      r_rsp_z     <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_tag   <= '0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          // req_ready follows the grant directly, so any valid is accepted.
          if (w_gnt_any) begin
            r_a      <= w_sel_a;
            r_b      <= w_sel_b;
            r_aluc   <= w_sel_aluc;
            r_tag    <= w_sel_tag;
            r_owner  <= w_gnt_idx;
            r_rr_ptr <= ~w_gnt_idx;
            r_busy   <= 1'b1;
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_s     <= w_err ? 32'd0 : w_alu_s;
          r_rsp_z     <= w_err | w_alu_z;
          r_rsp_err   <= w_err;
          r_rsp_tag   <= r_tag;
          r_rsp_valid <= 2'b01 << r_owner;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (w_rsp_hs) begin
            r_rsp_valid <= 2'b00;
            r_busy      <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 2'b00;
          r_busy      <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_s     = r_rsp_s;
  assign rsp_z     = r_rsp_z;
  assign rsp_err   = r_rsp_err;
  assign rsp_tag   = r_rsp_tag;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_share_arbiter
// Two instances share one clock and reset: index 0 is round-robin
// (PRIO_MODE=0), index 1 is fixed priority (PRIO_MODE=1). Directed vectors
// with hand-computed results are pushed into per-instance expected queues;
// a monitor pops and compares on every response transfer.
// Expected item layout: {rsp_valid[1:0], err, z, s[31:0], tag[3:0]}.
// -----------------------------------------------------------------------------
module tb_alu_share_arbiter;

  localparam int TAG_W = 4;
  localparam int IW    = 40;

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset;
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- DUT signals (per instance) ----------------
  logic [1:0]         req_valid_s [2];
  logic [1:0]         req_ready_s [2];
  logic [63:0]        req_a_s     [2];
  logic [63:0]        req_b_s     [2];
  logic [7:0]         req_aluc_s  [2];
  logic [7:0]         req_tag_s   [2];
  logic [1:0]         rsp_valid_s [2];
  logic [1:0]         rsp_ready_s [2];
  logic [31:0]        rsp_s_s     [2];
  logic               rsp_z_s     [2];
  logic               rsp_err_s   [2];
  logic [TAG_W-1:0]   rsp_tag_s   [2];
  logic               busy_s      [2];
  logic [1:0]         dbg_state_s [2];

  alu_share_arbiter #(.TAG_W(TAG_W), .PRIO_MODE(0)) dut_rr (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_s[0]), .req_ready(req_ready_s[0]),
    .req_a(req_a_s[0]), .req_b(req_b_s[0]), .req_aluc(req_aluc_s[0]), .req_tag(req_tag_s[0]),
    .rsp_valid(rsp_valid_s[0]), .rsp_ready(rsp_ready_s[0]),
    .rsp_s(rsp_s_s[0]), .rsp_z(rsp_z_s[0]), .rsp_err(rsp_err_s[0]), .rsp_tag(rsp_tag_s[0]),
    .busy(busy_s[0]), .dbg_state(dbg_state_s[0])
  );

  alu_share_arbiter #(.TAG_W(TAG_W), .PRIO_MODE(1)) dut_fp (
    .clock(clock), .reset(reset),
    .req_valid(req_valid_s[1]), .req_ready(req_ready_s[1]),
    .req_a(req_a_s[1]), .req_b(req_b_s[1]), .req_aluc(req_aluc_s[1]), .req_tag(req_tag_s[1]),
    .rsp_valid(rsp_valid_s[1]), .rsp_ready(rsp_ready_s[1]),
    .rsp_s(rsp_s_s[1]), .rsp_z(rsp_z_s[1]), .rsp_err(rsp_err_s[1]), .rsp_tag(rsp_tag_s[1]),
    .busy(busy_s[1]), .dbg_state(dbg_state_s[1])
  );

  // ---------------- scoreboard ----------------
  logic [IW-1:0] exp_q0[$];
  logic [IW-1:0] exp_q1[$];
  int            n_tests = 0;
  int            n_fail  = 0;
  logic          m_rr_ptr = 1'b0;   // model of dut_rr's round-robin pointer
  logic [IW-1:0] mon_act;
  logic [IW-1:0] mon_exp;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int k, input logic [IW-1:0] item);
    if (k == 0) exp_q0.push_back(item);
    else        exp_q1.push_back(item);
  endtask

  // Monitor: a transfer completes at the next rising edge whenever
  // rsp_valid & rsp_ready is non-zero mid-cycle.
  always @(negedge clock) begin
    if (!reset) begin
      for (int k = 0; k < 2; k++) begin
        if ((rsp_valid_s[k] & rsp_ready_s[k]) != 2'b00) begin
          mon_act = {rsp_valid_s[k], rsp_err_s[k], rsp_z_s[k], rsp_s_s[k], rsp_tag_s[k]};
          if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_rsp dut%0d: got %h expected none", k, mon_act);
          end else begin
            mon_exp = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("rsp_dut%0d", k), {24'd0, mon_act}, {24'd0, mon_exp});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input int k);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (!busy_s[k]) begin ok = 1'b1; break; end
    end
    if (!ok) chk($sformatf("idle_timeout_dut%0d", k), 64'(ok), 64'd1);
  endtask

  // One request from requester idx with the other side idle.
  task automatic single_op(input int k, input int idx, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] aluc, input logic [3:0] tag,
                           input logic [31:0] es, input logic ez, input logic ee, input bit hold);
    bit ok;
    logic [1:0] own;
    own = 2'b01 << idx;
    @(posedge clock); #1;
    req_a_s[k][idx*32 +: 32] = a;
    req_b_s[k][idx*32 +: 32] = b;
    req_aluc_s[k][idx*4 +: 4] = aluc;
    req_tag_s[k][idx*4 +: 4]  = tag;
    req_valid_s[k][idx]       = 1'b1;
    if (hold) rsp_ready_s[k][idx] = 1'b0;
    @(negedge clock);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (req_ready_s[k] == own) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    chk($sformatf("accept_dut%0d_op%h", k, aluc), 64'(ok), 64'd1);
    if (!ok) begin
      req_valid_s[k][idx] = 1'b0;
      rsp_ready_s[k][idx] = 1'b1;
      return;
    end
    push_exp(k, {own, ee, ez, es, tag});
    if (k == 0) m_rr_ptr = ~idx[0];
    @(posedge clock); #1;
    // Operands are only sampled at the transfer; scramble them afterwards.
    req_valid_s[k][idx]        = 1'b0;
    req_a_s[k][idx*32 +: 32]   = $urandom();
    req_b_s[k][idx*32 +: 32]   = $urandom();
    req_aluc_s[k][idx*4 +: 4]  = 4'($urandom_range(0, 15));
    @(negedge clock);
    chk("exec_phase", {60'd0, rsp_valid_s[k], busy_s[k], 1'b0} | {62'd0, dbg_state_s[k]} << 4,
        {60'd0, 2'b00, 1'b1, 1'b0} | 64'(2'd1) << 4);
    @(negedge clock);
    chk("latency", {60'd0, rsp_valid_s[k], dbg_state_s[k]}, {60'd0, own, 2'd2});
    if (hold) begin
      for (int c = 0; c < 5; c++) begin
        @(posedge clock);
        @(negedge clock);
        chk($sformatf("hold_stable_%0d", c),
            {20'd0, rsp_valid_s[k], req_ready_s[k], busy_s[k], rsp_err_s[k], rsp_z_s[k], rsp_s_s[k], rsp_tag_s[k]},
            {20'd0, own, 2'b00, 1'b1, ee, ez, es, tag});
      end
      @(posedge clock); #1;
      rsp_ready_s[k][idx] = 1'b1;
    end
    wait_idle(k);
  endtask

  // Both requesters valid continuously for n operations; grant order is
  // predicted by the bench model. Tags: requester 0 = A, requester 1 = 5.
  task automatic both_valid(input int k, input int n, input logic [31:0] a, input logic [31:0] b,
                            input logic [3:0] aluc, input logic [31:0] es, input logic ez);
    bit   got;
    logic w;
    @(posedge clock); #1;
    req_a_s[k]     = {a, a};
    req_b_s[k]     = {b, b};
    req_aluc_s[k]  = {aluc, aluc};
    req_tag_s[k]   = {4'h5, 4'hA};
    rsp_ready_s[k] = 2'b11;
    req_valid_s[k] = 2'b11;
    @(negedge clock);
    for (int i = 0; i < n; i++) begin
      w = (k == 1) ? 1'b0 : m_rr_ptr;
      push_exp(k, {2'(2'b01 << w), 1'b0, ez, es, (w ? 4'h5 : 4'hA)});
      got = 1'b0;
      for (int c = 0; c < 20; c++) begin
        if (req_ready_s[k] != 2'b00) begin got = 1'b1; break; end
        @(negedge clock);
      end
      chk($sformatf("grant%0d_dut%0d", i, k), {61'd0, got, req_ready_s[k]}, {61'd0, 1'b1, 2'(2'b01 << w)});
      if (!got) begin
        if (k == 0) void'(exp_q0.pop_back());
        else        void'(exp_q1.pop_back());
        break;
      end
      if (k == 0) m_rr_ptr = ~w;
      @(posedge clock);
      if (i == n - 1) begin #1; req_valid_s[k] = 2'b00; end
      wait_idle(k);
    end
    req_valid_s[k] = 2'b00;
  endtask

  // Reset asserted while dut_rr is in EXEC: the op must vanish.
  task automatic reset_mid_op();
    bit ok;
    @(posedge clock); #1;
    req_a_s[0][31:0]  = 32'd1;
    req_b_s[0][31:0]  = 32'd1;
    req_aluc_s[0][3:0] = 4'b0000;
    req_tag_s[0][3:0] = 4'h3;
    req_valid_s[0][0] = 1'b1;
    @(negedge clock);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (req_ready_s[0] == 2'b01) begin ok = 1'b1; break; end
      @(negedge clock);
    end
    chk("reset_op_accept", 64'(ok), 64'd1);
    @(posedge clock); #1;
    req_valid_s[0] = 2'b00;
    chk("reset_op_in_exec", 64'(dbg_state_s[0]), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_mid_op_outputs",
        {20'd0, rsp_valid_s[0], req_ready_s[0], busy_s[0], rsp_err_s[0], rsp_z_s[0], rsp_s_s[0], rsp_tag_s[0]} |
        ({62'd0, dbg_state_s[0]} << 44), 64'd0);
    @(posedge clock); #1;
    reset    = 1'b0;
    m_rr_ptr = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      chk($sformatf("no_stale_rsp_%0d", c), {62'd0, rsp_valid_s[0] | {1'b0, busy_s[0]}}, 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      req_valid_s[k] = 2'b00;
      req_a_s[k]     = '0;
      req_b_s[k]     = '0;
      req_aluc_s[k]  = '0;
      req_tag_s[k]   = '0;
      rsp_ready_s[k] = 2'b11;
    end
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    for (int k = 0; k < 2; k++)
      chk($sformatf("reset_state_dut%0d", k),
          {18'd0, dbg_state_s[k], rsp_valid_s[k], req_ready_s[k], busy_s[k], rsp_err_s[k], rsp_z_s[k], rsp_s_s[k], rsp_tag_s[k]},
          64'd0);

    //        k idx a             b             aluc     tag    exp_s         z     err  hold
    single_op(0, 0, 32'd5,         32'd3,         4'b0000, 4'h1, 32'd8,         1'b0, 1'b0, 0);
    single_op(0, 1, 32'd7,         32'd7,         4'b1000, 4'h2, 32'd0,         1'b1, 1'b0, 0);
    single_op(0, 0, 32'hFFFF_FFFF, 32'd1,         4'b0000, 4'h3, 32'd0,         1'b1, 1'b0, 0);
    single_op(0, 1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 4'b0111, 4'h4, 32'h00F0_00F0, 1'b0, 1'b0, 0);
    single_op(0, 0, 32'h1200_0034, 32'h0000_5600, 4'b0110, 4'h5, 32'h1200_5634, 1'b0, 1'b0, 0);
    single_op(0, 1, 32'hFFFF_0000, 32'h0F0F_0F0F, 4'b0100, 4'h6, 32'hF0F0_0F0F, 1'b0, 1'b0, 0);
    single_op(0, 0, 32'h0000_1234, 32'hDEAD_BEEF, 4'b0010, 4'h7, 32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    single_op(0, 1, 32'd1,         32'd4,         4'b0001, 4'h8, 32'd16,        1'b0, 1'b0, 0);
    single_op(0, 0, 32'd1,         32'd33,        4'b0001, 4'h9, 32'd0,         1'b1, 1'b0, 0);
    single_op(0, 1, 32'h8000_0000, 32'd31,        4'b0101, 4'hA, 32'd1,         1'b0, 1'b0, 0);
    single_op(0, 0, 32'hFF00_FF00, 32'h0,         4'b1111, 4'hB, 32'd16,        1'b0, 1'b0, 0);
    single_op(0, 1, 32'h8000_0000, 32'd4,         4'b1101, 4'hC, 32'hF800_0000, 1'b0, 1'b0, 0);
    single_op(0, 0, 32'h8000_0000, 32'd40,        4'b1101, 4'hD, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
    single_op(0, 1, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0011, 4'hE, 32'd0,         1'b1, 1'b1, 1);

    // Round-robin tie, sub 7-7: pointer is 0 here, so grants go 0,1,0,1.
    both_valid(0, 4, 32'd7, 32'd7, 4'b1000, 32'd0, 1'b1);
    // Fixed priority: requester 0 wins every tie.
    both_valid(1, 3, 32'd2, 32'd3, 4'b0000, 32'd5, 1'b0);

    reset_mid_op();
    // After reset the pointer is back at 0.
    both_valid(0, 2, 32'd9, 32'd4, 4'b1000, 32'd5, 1'b0);

    repeat (3) @(negedge clock);
    chk("queues_empty", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

endmodule
